// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants, types and hex decoder function for the 7-segment scan driver
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low {a,b,c,d,e,f,g}, indexed by hex nibble.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    typedef enum logic {
        PHASE_GUARD = 1'b0,
        PHASE_ON    = 1'b1
    } phase_t;

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
    } cathode_t;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// rtl/seg7_hex_decode.sv - combinational hex nibble to active-low segment decoder
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed common-anode 7-segment scan driver with double-buffered value
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 100000,
    parameter int GUARD      = 500,
    localparam int IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    lz_en,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [IDX_W-1:0]        slot_idx
);

    localparam int              PRE_W    = $clog2(SCAN_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_GRD  = PRE_W'(GUARD);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [4*NUM_DIGITS-1:0] shadow_value;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic [NUM_DIGITS-1:0]   shadow_en;
    logic                    shadow_lz;

    logic [PRE_W-1:0]        prescaler;
    logic [IDX_W-1:0]        slot_cnt;
    phase_t                  phase;

    logic [NUM_DIGITS-1:0]   lz_blank;
    logic                    zero_above;
    logic [3:0]              cur_nibble;
    logic                    cur_en;
    logic                    cur_dp;
    logic                    cur_lz;
    logic                    cur_blank;
    logic [NUM_DIGITS-1:0]   digit_onehot;
    logic [6:0]              dec_seg;
    logic [NUM_DIGITS-1:0]   next_anode;
    cathode_t                next_cath;

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_value <= '0;
            shadow_dp    <= '0;
            shadow_en    <= '0;
            shadow_lz    <= 1'b0;
        end else if (load) begin
            shadow_value <= value;
            shadow_dp    <= dp_in;
            shadow_en    <= digit_en;
            shadow_lz    <= lz_en;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler <= '0;
            slot_cnt  <= '0;
        end else if (prescaler == PRE_LAST) begin
            prescaler <= '0;
            slot_cnt  <= (slot_cnt == IDX_LAST) ? '0 : slot_cnt + IDX_W'(1);
        end else begin
            prescaler <= prescaler + PRE_W'(1);
        end
    end

    assign phase = (prescaler < PRE_GRD) ? PHASE_GUARD : PHASE_ON;

    // Walk down from the top digit; a digit is LZ-blanked while it and everything above it are zero.
    always_comb begin
        zero_above = 1'b1;
        lz_blank   = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_above  = zero_above && (shadow_value[4*i +: 4] == 4'h0);
            lz_blank[i] = shadow_lz && zero_above;
        end
    end

    always_comb begin
        cur_nibble   = 4'h0;
        cur_en       = 1'b0;
        cur_dp       = 1'b0;
        cur_lz       = 1'b0;
        digit_onehot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (slot_cnt == IDX_W'(i)) begin
                cur_nibble      = shadow_value[4*i +: 4];
                cur_en          = shadow_en[i];
                cur_dp          = shadow_dp[i];
                cur_lz          = lz_blank[i];
                digit_onehot[i] = 1'b1;
            end
        end
    end

    assign cur_blank = !cur_en || cur_lz;

    seg7_hex_decode u_dec (
        .nibble (cur_nibble),
        .seg    (dec_seg)
    );

    // Anode stays low for blanked digits so every slot has identical timing.
    always_comb begin
        next_anode = '1;
        next_cath  = '{seg: SEG_OFF, dp: 1'b1};
        if (phase == PHASE_ON) begin
            next_anode     = ~digit_onehot;
            next_cath.seg  = cur_blank ? SEG_OFF : dec_seg;
            next_cath.dp   = cur_en ? ~cur_dp : 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            anode    <= '1;
            seg      <= SEG_OFF;
            dp       <= 1'b1;
            slot_idx <= '0;
        end else begin
            anode    <= next_anode;
            seg      <= next_cath.seg;
            dp       <= next_cath.dp;
            slot_idx <= slot_cnt;
        end
    end

endmodule
